// File: rtl/fetch_unit.sv
// Instruction-fetch stage: program counter, memory request/ack handshake and
// instruction register. Optional fetch timeout is enabled with FETCH_TIMEOUT_EN.
module fetch_unit #(
    parameter int unsigned        DATA_W         = 16,
    parameter logic [DATA_W-1:0]  RESET_PC       = 16'h0000,
    parameter int unsigned        PC_STEP        = 2,
    parameter int unsigned        TIMEOUT_CYCLES = 64
) (
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic [DATA_W-1:0] NextPC,
    input  logic              Advance,
    input  logic              MemAck,
    input  logic [DATA_W-1:0] MemData,
    output logic [DATA_W-1:0] PC,
    output logic [DATA_W-1:0] PCPlus,
    output logic              MemReq,
    output logic [DATA_W-1:0] MemAddr,
    output logic [DATA_W-1:0] IR,
    output logic              IRValid,
    output logic              FetchErr
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_READY = 2'b10
    } state_t;

    // Instructions are half-word aligned, so the PC LSB is forced to zero.
    localparam logic [DATA_W-1:0] ALIGN_MASK_C = ~{{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] STEP_C       = DATA_W'(PC_STEP);
    localparam logic [DATA_W-1:0] RESET_PC_C   = RESET_PC & ALIGN_MASK_C;

    state_t            state_r;
    logic [DATA_W-1:0] pc_r;
    logic [DATA_W-1:0] ir_r;
    logic              irvalid_r;
    logic              memreq_r;
    logic [DATA_W-1:0] next_pc_s;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned     CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LAST_C = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] tmo_cnt_r;
    logic             fetcherr_r;
`endif

    assign next_pc_s = NextPC & ALIGN_MASK_C;

    // Fetch FSM with all datapath registers; reset has priority over every input.
    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            state_r   <= ST_IDLE;
            pc_r      <= RESET_PC_C;
            ir_r      <= {DATA_W{1'b0}};
            irvalid_r <= 1'b0;
            memreq_r  <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            tmo_cnt_r  <= {CNT_W{1'b0}};
            fetcherr_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r  <= ST_FETCH;
                    memreq_r <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                    tmo_cnt_r <= {CNT_W{1'b0}};
`endif
                end
                ST_FETCH: begin
                    if (MemAck) begin
                        ir_r      <= MemData;
                        irvalid_r <= 1'b1;
                        memreq_r  <= 1'b0;
                        state_r   <= ST_READY;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (tmo_cnt_r == TMO_LAST_C) begin
                        // Drop the request; IDLE re-issues it from the same PC.
                        fetcherr_r <= 1'b1;
                        memreq_r   <= 1'b0;
                        state_r    <= ST_IDLE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
                    end
`else
                    else begin
                        memreq_r <= 1'b1;
                    end
`endif
                end
                ST_READY: begin
                    if (Advance) begin
                        pc_r      <= next_pc_s;
                        irvalid_r <= 1'b0;
                        memreq_r  <= 1'b1;
                        state_r   <= ST_FETCH;
`ifdef FETCH_TIMEOUT_EN
                        tmo_cnt_r <= {CNT_W{1'b0}};
`endif
                    end else begin
                        irvalid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    memreq_r  <= 1'b0;
                    irvalid_r <= 1'b0;
                end
            endcase
        end
    end

    assign PC      = pc_r;
    assign PCPlus  = pc_r + STEP_C;
    assign MemAddr = pc_r;
    assign MemReq  = memreq_r;
    assign IR      = ir_r;
    assign IRValid = irvalid_r;
`ifdef FETCH_TIMEOUT_EN
    assign FetchErr = fetcherr_r;
`else
    assign FetchErr = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// against a transaction-level model (outstanding request / valid instruction).
module tb_fetch_unit;

    localparam int TMO = 4;
`ifdef FETCH_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        Reset_n = 1'b0;
    logic [15:0] NextPC = 16'h0000;
    logic        Advance = 1'b0;
    logic        MemAck = 1'b0;
    logic [15:0] MemData = 16'h0000;
    logic [15:0] PC, PCPlus, MemAddr, IR;
    logic        MemReq, IRValid, FetchErr;

    int checks = 0;
    int errors = 0;

    // Model: PC, IR, whether a request is outstanding, whether IR is valid,
    // how many cycles the current request has waited, sticky error.
    logic [15:0] m_pc;
    logic [15:0] m_ir;
    bit          m_req;
    bit          m_valid;
    int          m_wait;
    bit          m_err;

    fetch_unit #(
        .DATA_W(16), .RESET_PC(16'h0000), .PC_STEP(2), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK(CLK), .Reset_n(Reset_n), .NextPC(NextPC), .Advance(Advance),
        .MemAck(MemAck), .MemData(MemData), .PC(PC), .PCPlus(PCPlus),
        .MemReq(MemReq), .MemAddr(MemAddr), .IR(IR), .IRValid(IRValid),
        .FetchErr(FetchErr)
    );

    always #5 CLK = ~CLK;

    task automatic model_step(input bit rst_n, input bit adv, input bit ack,
                              input logic [15:0] npc, input logic [15:0] data);
        if (!rst_n) begin
            m_pc = 16'h0000; m_ir = 16'h0000; m_req = 0; m_valid = 0;
            m_wait = 0; m_err = 0;
        end else if (m_req) begin
            if (ack) begin
                m_ir = data; m_valid = 1; m_req = 0;
            end else if (TMO_EN) begin
                m_wait++;
                if (m_wait == TMO) begin
                    m_err = 1; m_req = 0;
                end
            end
        end else if (m_valid) begin
            if (adv) begin
                m_pc = {npc[15:1], 1'b0}; m_valid = 0; m_req = 1; m_wait = 0;
            end
        end else begin
            m_req = 1; m_wait = 0;
        end
    endtask

    // Apply inputs, take one rising edge, update the model, settle before sampling.
    task automatic cycle(input bit rst_n, input bit adv, input bit ack,
                         input logic [15:0] npc, input logic [15:0] data);
        Reset_n = rst_n; Advance = adv; MemAck = ack; NextPC = npc; MemData = data;
        @(posedge CLK);
        model_step(rst_n, adv, ack, npc, data);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 16'h1234, 16'hFFFF);
        checks++; if (PC !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h exp 0000", PC); end
        checks++; if (PCPlus !== 16'h0002) begin errors++; $display("FAIL reset_pcplus got %h exp 0002", PCPlus); end
        checks++; if (MemReq !== 1'b0) begin errors++; $display("FAIL reset_memreq got %b exp 0", MemReq); end
        checks++; if (IRValid !== 1'b0) begin errors++; $display("FAIL reset_irvalid got %b exp 0", IRValid); end
        checks++; if (IR !== 16'h0000) begin errors++; $display("FAIL reset_ir got %h exp 0000", IR); end
        checks++; if (FetchErr !== 1'b0) begin errors++; $display("FAIL reset_fetcherr got %b exp 0", FetchErr); end
        cycle(1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000);
        checks++; if (MemReq !== 1'b1) begin errors++; $display("FAIL release_memreq got %b exp 1", MemReq); end
        checks++; if (MemAddr !== 16'h0000) begin errors++; $display("FAIL release_memaddr got %h exp 0000", MemAddr); end
    endtask

    task automatic test_fetch();
        cycle(1'b1, 1'b0, 1'b1, 16'h0000, 16'hA5C3);
        checks++; if (IR !== 16'hA5C3) begin errors++; $display("FAIL fetch_ir got %h exp a5c3", IR); end
        checks++; if (IRValid !== 1'b1) begin errors++; $display("FAIL fetch_irvalid got %b exp 1", IRValid); end
        checks++; if (MemReq !== 1'b0) begin errors++; $display("FAIL fetch_memreq got %b exp 0", MemReq); end
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 16'h0000, 16'($urandom));
        checks++; if (IR !== 16'hA5C3) begin errors++; $display("FAIL ready_ir_hold got %h exp a5c3", IR); end
        checks++; if (IRValid !== 1'b1) begin errors++; $display("FAIL ready_valid_hold got %b exp 1", IRValid); end
    endtask

    task automatic test_advance();
        cycle(1'b1, 1'b1, 1'b0, 16'h0041, 16'h0000);
        checks++; if (PC !== 16'h0040) begin errors++; $display("FAIL advance_pc got %h exp 0040", PC); end
        checks++; if (IRValid !== 1'b0) begin errors++; $display("FAIL advance_irvalid got %b exp 0", IRValid); end
        checks++; if (MemReq !== 1'b1) begin errors++; $display("FAIL advance_memreq got %b exp 1", MemReq); end
        checks++; if (MemAddr !== 16'h0040) begin errors++; $display("FAIL advance_memaddr got %h exp 0040", MemAddr); end
        cycle(1'b1, 1'b1, 1'b0, 16'h1234, 16'h0000);
        checks++; if (PC !== 16'h0040) begin errors++; $display("FAIL advance_in_fetch got %h exp 0040", PC); end
    endtask

    task automatic test_wrap();
        cycle(1'b1, 1'b0, 1'b1, 16'h0000, 16'h1111);
        cycle(1'b1, 1'b1, 1'b0, 16'hFFFE, 16'h0000);
        checks++; if (PC !== 16'hFFFE) begin errors++; $display("FAIL wrap_pc got %h exp fffe", PC); end
        checks++; if (PCPlus !== 16'h0000) begin errors++; $display("FAIL wrap_pcplus got %h exp 0000", PCPlus); end
        cycle(1'b1, 1'b0, 1'b1, 16'h0000, 16'h7E01);
        checks++; if (IR !== 16'h7E01) begin errors++; $display("FAIL wrap_ir got %h exp 7e01", IR); end
    endtask

    task automatic test_reset_mid_fetch();
        cycle(1'b1, 1'b1, 1'b0, 16'h2223, 16'h0000);
        cycle(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        checks++; if (PC !== 16'h2222) begin errors++; $display("FAIL lsb_clear_pc got %h exp 2222", PC); end
        cycle(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        checks++; if (MemReq !== 1'b0) begin errors++; $display("FAIL midreset_memreq got %b exp 0", MemReq); end
        cycle(1'b1, 1'b0, 1'b1, 16'h0000, 16'hBEEF);
        checks++; if (IR !== 16'h0000) begin errors++; $display("FAIL late_ack_ir got %h exp 0000", IR); end
        checks++; if (IRValid !== 1'b0) begin errors++; $display("FAIL late_ack_irvalid got %b exp 0", IRValid); end
        checks++; if (MemReq !== 1'b1 || MemAddr !== 16'h0000) begin
            errors++; $display("FAIL rerequest got req=%b addr=%h exp req=1 addr=0000", MemReq, MemAddr);
        end
    endtask

    task automatic test_timeout();
`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < TMO - 1; i++) cycle(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        checks++; if (FetchErr !== 1'b0 || MemReq !== 1'b1) begin
            errors++; $display("FAIL pre_timeout got err=%b req=%b exp err=0 req=1", FetchErr, MemReq);
        end
        cycle(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        checks++; if (FetchErr !== 1'b1 || MemReq !== 1'b0) begin
            errors++; $display("FAIL timeout got err=%b req=%b exp err=1 req=0", FetchErr, MemReq);
        end
        cycle(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        checks++; if (MemReq !== 1'b1 || MemAddr !== 16'h0000) begin
            errors++; $display("FAIL retry got req=%b addr=%h exp req=1 addr=0000", MemReq, MemAddr);
        end
        cycle(1'b1, 1'b0, 1'b1, 16'h0000, 16'h3C3C);
        checks++; if (IRValid !== 1'b1 || IR !== 16'h3C3C || FetchErr !== 1'b1) begin
            errors++; $display("FAIL retry_done got v=%b ir=%h err=%b exp v=1 ir=3c3c err=1", IRValid, IR, FetchErr);
        end
`else
        for (int i = 0; i < 100; i++) cycle(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        checks++; if (MemReq !== 1'b1 || IRValid !== 1'b0 || FetchErr !== 1'b0) begin
            errors++; $display("FAIL no_timeout got req=%b v=%b err=%b exp req=1 v=0 err=0", MemReq, IRValid, FetchErr);
        end
        cycle(1'b1, 1'b0, 1'b1, 16'h0000, 16'h3C3C);
        checks++; if (IRValid !== 1'b1 || IR !== 16'h3C3C) begin
            errors++; $display("FAIL late_fetch got v=%b ir=%h exp v=1 ir=3c3c", IRValid, IR);
        end
`endif
    endtask

    task automatic test_random();
        logic [15:0] exp_plus;
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 39) != 0), 1'($urandom), ($urandom_range(0, 2) == 0),
                  16'($urandom), 16'($urandom));
            exp_plus = m_pc + 16'd2;
            checks++;
            if (PC !== m_pc || PCPlus !== exp_plus || MemAddr !== m_pc || IR !== m_ir ||
                MemReq !== m_req || IRValid !== m_valid || FetchErr !== m_err) begin
                errors++;
                $display("FAIL random[%0d] got pc=%h pp=%h addr=%h ir=%h req=%b v=%b err=%b exp pc=%h pp=%h ir=%h req=%b v=%b err=%b",
                         i, PC, PCPlus, MemAddr, IR, MemReq, IRValid, FetchErr,
                         m_pc, exp_plus, m_ir, m_req, m_valid, m_err);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_fetch();
        test_advance();
        test_wrap();
        test_reset_mid_fetch();
        test_timeout();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
